// File: rtl/mem_responder.sv
// Word-addressed synchronous memory responding to the datapath MAR/MDR interface with a
// programmable wait before a one-cycle Ready pulse. Optional bounds checking: MEM_BOUNDS_CHECK_EN.
module mem_responder #(
    parameter int DEPTH       = 512,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Read,
    input  logic        Write,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] MemDataOut,
    output logic        Ready,
    output logic        Busy,
    output logic        Err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t             state;
    state_t             next_state;
    logic [3:0]         wait_cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic               op_write_q;
    logic               oob_q;
    logic               oob_in;
    logic               accept;

    logic [ADDR_W-1:0]  cur_addr;
    logic [31:0]        cur_wdata;
    logic               cur_write;
    logic               cur_oob;
    logic               ready_d;
    logic               busy_d;
    logic               err_d;
    logic               do_write;
    logic               do_read;

    logic [31:0]        mem [DEPTH];

`ifdef MEM_BOUNDS_CHECK_EN
    assign oob_in = (Address >= 32'(DEPTH));
`else
    // Upper address bits are deliberately dropped so addresses wrap modulo DEPTH.
    logic unused_addr_hi;
    assign unused_addr_hi = ^Address[31:ADDR_W];
    assign oob_in         = 1'b0;
`endif

    assign accept = (state == IDLE) && (Read || Write);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= next_state;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (Read || Write) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT: if (wait_cnt == 4'd0) next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // With no wait states the RAM access happens on the accept edge itself, so the live
    // request inputs are used while idle and the latched copy afterwards.
    always_comb begin
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_write = op_write_q;
        cur_oob   = oob_q;
        if (state == IDLE) begin
            cur_addr  = Address[ADDR_W-1:0];
            cur_wdata = WriteData;
            cur_write = Write && !Read;
            cur_oob   = oob_in;
        end
        ready_d  = (next_state == RESP);
        busy_d   = (next_state != IDLE);
        err_d    = ready_d && cur_oob;
        do_write = ready_d && cur_write && !cur_oob && Resetn;
        do_read  = ready_d && !cur_write;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wait_cnt   <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            oob_q      <= 1'b0;
            MemDataOut <= '0;
            Ready      <= 1'b0;
            Busy       <= 1'b0;
            Err        <= 1'b0;
        end else begin
            Ready <= ready_d;
            Busy  <= busy_d;
            Err   <= err_d;
            if (accept) begin
                addr_q     <= Address[ADDR_W-1:0];
                wdata_q    <= WriteData;
                op_write_q <= Write && !Read;
                oob_q      <= oob_in;
                wait_cnt   <= WAIT_LOAD;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (do_read) MemDataOut <= cur_oob ? 32'h0000_0000 : mem[cur_addr];
        end
    end

    // NOTE: the RAM array has no reset; contents survive Resetn and map onto block RAM.
    always_ff @(posedge Clock) begin
        if (do_write) mem[cur_addr] <= cur_wdata;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances with WAIT_CYCLES = 0, 1, 2 (instance i uses i).
// Stimulus pushes expected responses; a negedge monitor pops and compares on every Ready.
module tb_mem_responder;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        rd    [3];
    logic        wr    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] dout  [3];
    logic        rdy   [3];
    logic        busy  [3];
    logic        err   [3];

    exp_t        sb_q [3][$];
    logic [31:0] held [3];
    int          n_checks = 0;
    int          n_err    = 0;

    mem_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_CYCLES(0)) u_w0 (
        .Clock(clk), .Resetn(rst_n), .Read(rd[0]), .Write(wr[0]), .Address(addr[0]),
        .WriteData(wdata[0]), .MemDataOut(dout[0]), .Ready(rdy[0]), .Busy(busy[0]), .Err(err[0]));
    mem_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_CYCLES(1)) u_w1 (
        .Clock(clk), .Resetn(rst_n), .Read(rd[1]), .Write(wr[1]), .Address(addr[1]),
        .WriteData(wdata[1]), .MemDataOut(dout[1]), .Ready(rdy[1]), .Busy(busy[1]), .Err(err[1]));
    mem_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_CYCLES(2)) u_w2 (
        .Clock(clk), .Resetn(rst_n), .Read(rd[2]), .Write(wr[2]), .Address(addr[2]),
        .WriteData(wdata[2]), .MemDataOut(dout[2]), .Ready(rdy[2]), .Busy(busy[2]), .Err(err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Expected response: reads update the held value, writes must leave it unchanged.
    task automatic push(input int i, input logic is_rd, input bit oob, input logic [31:0] rd_val);
        exp_t e;
        e.err = oob && BCHK;
        if (is_rd) begin
            e.data  = (oob && BCHK) ? 32'h0 : rd_val;
            held[i] = e.data;
        end else begin
            e.data = held[i];
        end
        sb_q[i].push_back(e);
    endtask

    task automatic req(input int i, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd_val, input bit oob);
        int n;
        @(negedge clk);
        rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = d;
        push(i, r, oob, rd_val);
        @(posedge clk);
        #1;
        rd[i] = 1'b0; wr[i] = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (rdy[i]) break;
        end
        check($sformatf("latency[%0d]@%0h", i, a), 32'(n), 32'(i + 1));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (err[i] && !rdy[i]) check($sformatf("err_without_ready[%0d]", i), 32'(err[i]), 32'h0);
                if (rdy[i]) begin
                    check($sformatf("ready_implies_busy[%0d]", i), 32'(busy[i]), 32'h1);
                    if (sb_q[i].size() == 0) begin
                        check($sformatf("unexpected_ready[%0d]", i), 32'(rdy[i]), 32'h0);
                    end else begin
                        exp_t e;
                        e = sb_q[i].pop_front();
                        check($sformatf("rsp_data[%0d]", i), dout[i], e.data);
                        check($sformatf("rsp_err[%0d]", i), 32'(err[i]), 32'(e.err));
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] seq_val [3];
        logic [31:0] stable_v;
        int          gap;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0; held[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_dout[%0d]", i), dout[i], 32'h0);
            check($sformatf("reset_ready[%0d]", i), 32'(rdy[i]), 32'h0);
            check($sformatf("reset_busy[%0d]", i), 32'(busy[i]), 32'h0);
            check($sformatf("reset_err[%0d]", i), 32'(err[i]), 32'h0);
        end
        rst_n = 1'b1;

        // Zero wait states: write then read, Read+Write priority, bounds/wrap, last valid word.
        req(0, 1'b0, 1'b1, 32'd5,   32'h8091_8000, 32'h0, 1'b0);
        req(0, 1'b1, 1'b0, 32'd5,   32'h0,         32'h8091_8000, 1'b0);
        req(0, 1'b0, 1'b1, 32'd7,   32'h0000_0014, 32'h0, 1'b0);
        req(0, 1'b1, 1'b1, 32'd7,   32'h0000_0012, 32'h0000_0014, 1'b0);
        req(0, 1'b1, 1'b0, 32'd7,   32'h0,         32'h0000_0014, 1'b0);
        req(0, 1'b0, 1'b1, 32'd88,  32'h1111_2222, 32'h0, 1'b0);
        req(0, 1'b0, 1'b1, 32'd600, 32'hCAFE_0001, 32'h0, 1'b1);
        req(0, 1'b1, 1'b0, 32'd600, 32'h0,         32'hCAFE_0001, 1'b1);
        req(0, 1'b1, 1'b0, 32'd88,  32'h0,         BCHK ? 32'h1111_2222 : 32'hCAFE_0001, 1'b0);
        req(0, 1'b1, 1'b0, 32'h205, 32'h0,         32'h8091_8000, 1'b1);
        req(0, 1'b0, 1'b1, 32'd511, 32'h01FF_0000, 32'h0, 1'b0);
        req(0, 1'b1, 1'b0, 32'd511, 32'h0,         32'h01FF_0000, 1'b0);

        // One wait state, Read held high: a Ready every 3 cycles, data stable in between.
        seq_val[0] = 32'hAAAA_0001; seq_val[1] = 32'hAAAA_0002; seq_val[2] = 32'hAAAA_0003;
        for (int k = 0; k < 3; k++) req(1, 1'b0, 1'b1, 32'(k + 1), seq_val[k], 32'h0, 1'b0);
        stable_v = held[1];
        @(negedge clk);
        addr[1] = 32'd1;
        for (int k = 0; k < 3; k++) push(1, 1'b1, 1'b0, seq_val[k]);
        rd[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            while (gap < 20) begin
                @(negedge clk);
                gap++;
                if (rdy[1]) break;
                check($sformatf("hold_stable[%0d]", k), dout[1], stable_v);
            end
            check($sformatf("pulse_gap[%0d]", k), 32'(gap), (k == 0) ? 32'd2 : 32'd3);
            stable_v = seq_val[k];
            addr[1]  = 32'(k + 2);
        end
        rd[1] = 1'b0;

        // Two wait states: Busy profile, strobe during WAIT ignored.
        req(2, 1'b0, 1'b1, 32'd9, 32'hA5A5_0009, 32'h0, 1'b0);
        @(negedge clk);
        rd[2] = 1'b1; addr[2] = 32'd9;
        push(2, 1'b1, 1'b0, 32'hA5A5_0009);
        @(posedge clk);
        #1 rd[2] = 1'b0;
        @(negedge clk);
        check("w2_cyc1_busy", 32'(busy[2]), 32'h1);
        check("w2_cyc1_ready", 32'(rdy[2]), 32'h0);
        rd[2] = 1'b1; addr[2] = 32'd7;
        @(posedge clk);
        #1 rd[2] = 1'b0;
        @(negedge clk);
        check("w2_cyc2_busy", 32'(busy[2]), 32'h1);
        check("w2_cyc2_ready", 32'(rdy[2]), 32'h0);
        @(negedge clk);
        check("w2_cyc3_busy", 32'(busy[2]), 32'h1);
        check("w2_cyc3_ready", 32'(rdy[2]), 32'h1);
        repeat (3) begin
            @(negedge clk);
            check("w2_after_busy", 32'(busy[2]), 32'h0);
        end

        // Reset mid-WAIT aborts a pending write; RAM keeps its old word.
        @(negedge clk);
        wr[2] = 1'b1; addr[2] = 32'd9; wdata[2] = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 wr[2] = 1'b0;
        @(negedge clk);
        check("abort_busy_before", 32'(busy[2]), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midreset_dout[%0d]", i), dout[i], 32'h0);
            check($sformatf("midreset_ready[%0d]", i), 32'(rdy[i]), 32'h0);
            check($sformatf("midreset_busy[%0d]", i), 32'(busy[i]), 32'h0);
            held[i] = 32'h0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_idle", 32'(busy[2]), 32'h0);
        end
        req(2, 1'b1, 1'b0, 32'd9, 32'h0, 32'hA5A5_0009, 1'b0);

        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("sb_drained[%0d]", i), 32'(sb_q[i].size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
